// File: rtl/laser_pkg.sv
// Shared encodings and constants for the laser pulse sequencer.
package laser_pkg;

    localparam int unsigned MODE_W     = 2;
    localparam int unsigned MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_CONT   = 2'b01,
        MODE_SINGLE = 2'b10,
        MODE_BURST  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_RUN   = 2'b10,
        ST_FAULT = 2'b11
    } state_e;

endpackage

// File: rtl/pulse_channel.sv
// One output channel: window compare against the period counter, registered.
module pulse_channel
    import laser_pkg::*;
#(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] last_i,
    output logic             pulse_o
);

    logic [CNT_W:0] stop_c;
    logic           hit_c;
    logic           pulse_q;

    // Extra bit keeps delay+width from wrapping; the last count of a period is never driven.
    assign stop_c = {1'b0, delay_i} + {1'b0, width_i};
    assign hit_c  = (cnt_i >= delay_i) && ({1'b0, cnt_i} < stop_c) && (cnt_i < last_i);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= en_i & hit_c;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/laser_pulse_sequencer.sv
// Multi-channel laser pulse sequencer with trigger modes, shadow config and fault interlock.
module laser_pulse_sequencer
    import laser_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned BURST_W = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cfg_update,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] delay,
    input  logic [NUM_CH*CNT_W-1:0] pulse_width,
    input  logic [MODE_W-1:0]       mode,
    input  logic [BURST_W-1:0]      burst_count,
    input  logic                    sw_trigger,
    input  logic                    trigger_ext,
    input  logic                    fault,
    input  logic                    fault_clear,
    output logic [NUM_CH-1:0]       pulse_out,
    output logic                    period_active,
    output logic                    busy,
    output logic                    fault_latched,
    output logic                    laser_disable,
    output logic [BURST_W-1:0]      periods_done
);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BURST_W-1:0]        pd_q, pd_d;
    logic [CNT_W-1:0]          period_q, period_d;
    logic [NUM_CH*CNT_W-1:0]   delay_q, delay_d;
    logic [NUM_CH*CNT_W-1:0]   width_q, width_d;
    logic [BURST_W-1:0]        burst_q, burst_d;
    logic                      pend_q, pend_d;
    logic                      sync1_q, sync2_q, sync3_q;
    logic                      rst_done_q;
    logic                      period_active_q, busy_q, fault_latched_q, laser_disable_q;

    mode_e                     mode_c;
    logic                      trig_c;
    logic [CNT_W-1:0]          p_eff_c;
    logic [CNT_W-1:0]          last_c;
    logic                      at_end_c;
    logic [BURST_W-1:0]        pd_inc_c;
    logic                      load_c;
    logic                      run_en_c;

    assign mode_c   = mode_e'(mode);
    assign trig_c   = sw_trigger | (sync2_q & ~sync3_q);
    assign p_eff_c  = (period_q < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_q;
    assign last_c   = p_eff_c - CNT_W'(1);
    assign at_end_c = (state_q == ST_RUN) && (cnt_q == last_c);
    assign pd_inc_c = (pd_q == {BURST_W{1'b1}}) ? pd_q : pd_q + BURST_W'(1);
    assign run_en_c = (state_q == ST_RUN) && !fault;

    // Next state, period counter and burst counter; fault overrides everything and freezes counters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pd_d    = pd_q;
        if (fault) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    case (mode_c)
                        MODE_CONT:   state_d = ST_RUN;
                        MODE_SINGLE,
                        MODE_BURST:  state_d = ST_ARMED;
                        default:     state_d = ST_IDLE;
                    endcase
                end
                ST_ARMED: begin
                    if (mode_c == MODE_OFF) begin
                        state_d = ST_IDLE;
                    end else if (trig_c && !(mode_c == MODE_BURST && burst_q == '0)) begin
                        state_d = ST_RUN;
                        pd_d    = '0;
                    end
                end
                ST_RUN: begin
                    if (mode_c == MODE_OFF) begin
                        state_d = ST_IDLE;
                    end else if (at_end_c) begin
                        case (mode_c)
                            MODE_SINGLE: state_d = ST_ARMED;
                            MODE_BURST: begin
                                pd_d = pd_inc_c;
                                if (pd_inc_c >= burst_q) begin
                                    state_d = ST_ARMED;
                                end
                            end
                            default: state_d = ST_RUN;
                        endcase
                    end
                end
                ST_FAULT: begin
                    if (fault_clear) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (state_d == ST_RUN) begin
                cnt_d = (state_q == ST_RUN && !at_end_c) ? cnt_q + CNT_W'(1) : '0;
            end
        end
    end

    // Shadow config: loads immediately outside RUN, otherwise deferred to the period boundary.
    always_comb begin
        pend_d   = pend_q | cfg_update;
        load_c   = 1'b0;
        period_d = period_q;
        delay_d  = delay_q;
        width_d  = width_q;
        burst_d  = burst_q;
        if (state_q == ST_IDLE || state_q == ST_ARMED || (at_end_c && !fault)) begin
            load_c = cfg_update | pend_q;
        end
        if (load_c) begin
            period_d = period;
            delay_d  = delay;
            width_d  = pulse_width;
            burst_d  = burst_count;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            pd_q            <= '0;
            period_q        <= '0;
            delay_q         <= '0;
            width_q         <= '0;
            burst_q         <= '0;
            pend_q          <= 1'b0;
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            sync3_q         <= 1'b0;
            rst_done_q      <= 1'b0;
            period_active_q <= 1'b0;
            busy_q          <= 1'b0;
            fault_latched_q <= 1'b0;
            laser_disable_q <= 1'b1;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pd_q            <= pd_d;
            period_q        <= period_d;
            delay_q         <= delay_d;
            width_q         <= width_d;
            burst_q         <= burst_d;
            pend_q          <= pend_d;
            sync1_q         <= trigger_ext;
            sync2_q         <= sync1_q;
            sync3_q         <= sync2_q;
            rst_done_q      <= 1'b1;
            period_active_q <= run_en_c;
            busy_q          <= (state_d == ST_RUN);
            fault_latched_q <= (state_d == ST_FAULT);
            laser_disable_q <= !rst_done_q || (state_d == ST_FAULT);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pulse_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rstn    (rstn),
            .en_i    (run_en_c),
            .cnt_i   (cnt_q),
            .delay_i (delay_q[g*CNT_W +: CNT_W]),
            .width_i (width_q[g*CNT_W +: CNT_W]),
            .last_i  (last_c),
            .pulse_o (pulse_out[g])
        );
    end

    assign period_active = period_active_q;
    assign busy          = busy_q;
    assign fault_latched = fault_latched_q;
    assign laser_disable = laser_disable_q;
    assign periods_done  = pd_q;

endmodule

// File: tb/tb_laser_pulse_sequencer.sv
// Scoreboard bench: stimulus queues expected pulse vectors, a monitor pops them per active cycle.
module tb_laser_pulse_sequencer;

    logic        clk;
    logic        rstn;
    logic        cfg_update;
    logic [23:0] period;
    logic [47:0] delay;
    logic [47:0] pulse_width;
    logic [1:0]  mode;
    logic [15:0] burst_count;
    logic        sw_trigger;
    logic        trigger_ext;
    logic        fault;
    logic        fault_clear;
    logic [1:0]  pulse_out;
    logic        period_active;
    logic        busy;
    logic        fault_latched;
    logic        laser_disable;
    logic [15:0] periods_done;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [1:0]  exp_q[$];
    logic [1:0]  mon_exp;

    laser_pulse_sequencer #(
        .NUM_CH  (2),
        .CNT_W   (24),
        .BURST_W (16)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_update    (cfg_update),
        .period        (period),
        .delay         (delay),
        .pulse_width   (pulse_width),
        .mode          (mode),
        .burst_count   (burst_count),
        .sw_trigger    (sw_trigger),
        .trigger_ext   (trigger_ext),
        .fault         (fault),
        .fault_clear   (fault_clear),
        .pulse_out     (pulse_out),
        .period_active (period_active),
        .busy          (busy),
        .fault_latched (fault_latched),
        .laser_disable (laser_disable),
        .periods_done  (periods_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [1:0] exp_pulse(input int c, input int p, input int d0, input int w0,
                                             input int d1, input int w1);
        int pe;
        logic [1:0] r;
        pe   = (p < 2) ? 2 : p;
        r[0] = (c >= d0) && (c < d0 + w0) && (c < pe - 1);
        r[1] = (c >= d1) && (c < d1 + w1) && (c < pe - 1);
        return r;
    endfunction

    task automatic push_period(input int p, input int d0, input int w0, input int d1, input int w1);
        int pe;
        pe = (p < 2) ? 2 : p;
        for (int c = 0; c < pe; c++) exp_q.push_back(exp_pulse(c, p, d0, w0, d1, w1));
    endtask

    task automatic set_cfg(input int p, input int d0, input int w0, input int d1, input int w1,
                           input int bc);
        period      = 24'(p);
        delay       = {24'(d1), 24'(d0)};
        pulse_width = {24'(w1), 24'(w0)};
        burst_count = 16'(bc);
        cfg_update  = 1'b1;
        cyc(1);
        cfg_update  = 1'b0;
    endtask

    task automatic sw_pulse();
        sw_trigger = 1'b1;
        cyc(1);
        sw_trigger = 1'b0;
    endtask

    // Monitor: each registered active cycle must match the next queued vector.
    always @(negedge clk) begin
        if (period_active === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_active: pulse_out=%b with no expected entry at %0t",
                         pulse_out, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pulse_out_sb", int'(pulse_out), int'(mon_exp));
            end
        end
    end

    initial begin
        rstn = 1'b0; cfg_update = 1'b0; period = '0; delay = '0; pulse_width = '0;
        mode = 2'b00; burst_count = '0; sw_trigger = 1'b0; trigger_ext = 1'b0;
        fault = 1'b0; fault_clear = 1'b0;

        // Reset values
        cyc(3);
        chk("rst_pulse_out", int'(pulse_out), 0);
        chk("rst_period_active", int'(period_active), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fault_latched", int'(fault_latched), 0);
        chk("rst_laser_disable", int'(laser_disable), 1);
        chk("rst_periods_done", int'(periods_done), 0);
        rstn = 1'b1;
        cyc(4);
        chk("laser_disable_release", int'(laser_disable), 0);

        // Continuous P=10: ch0 counts 2..4, ch1 width 20 clamped at c=9, five periods
        set_cfg(10, 2, 3, 5, 20, 0);
        for (int k = 0; k < 5; k++) push_period(10, 2, 3, 5, 20);
        mode = 2'b01;
        cyc(10);
        chk("cont_busy", int'(busy), 1);
        cyc(40);
        mode = 2'b00;
        cyc(3);
        chk("cont_stop_busy", int'(busy), 0);
        chk("cont_drained", exp_q.size(), 0);

        // Single period with P=1 behaves as P=2
        set_cfg(1, 0, 1, 0, 5, 0);
        mode = 2'b10;
        cyc(2);
        push_period(2, 0, 1, 0, 5);
        sw_pulse();
        cyc(6);
        chk("p1_busy", int'(busy), 0);
        chk("p1_periods_done", int'(periods_done), 0);
        chk("p1_drained", exp_q.size(), 0);

        // External trigger: RUN three clocks after the pin edge, one period only
        set_cfg(10, 2, 3, 5, 20, 0);
        push_period(10, 2, 3, 5, 20);
        trigger_ext = 1'b1;
        cyc(2);
        chk("ext_busy_early", int'(busy), 0);
        cyc(1);
        chk("ext_busy_run", int'(busy), 1);
        cyc(14);
        trigger_ext = 1'b0;
        cyc(3);
        chk("ext_busy_done", int'(busy), 0);
        chk("ext_drained", exp_q.size(), 0);

        // Burst of 3 with an ignored retrigger during RUN
        set_cfg(10, 2, 3, 5, 20, 3);
        mode = 2'b11;
        cyc(1);
        for (int k = 0; k < 3; k++) push_period(10, 2, 3, 5, 20);
        sw_pulse();
        cyc(5);
        chk("burst_busy", int'(busy), 1);
        sw_pulse();
        cyc(12);
        chk("burst_pd_mid", int'(periods_done), 1);
        cyc(20);
        chk("burst_pd_end", int'(periods_done), 3);
        chk("burst_armed_idle", int'(busy), 0);
        chk("burst_drained", exp_q.size(), 0);

        // Burst count 0: trigger produces no run
        set_cfg(10, 2, 3, 5, 20, 0);
        sw_pulse();
        cyc(3);
        chk("burst0_busy", int'(busy), 0);
        chk("burst0_pd_held", int'(periods_done), 3);
        cyc(12);

        // Mid-run reconfiguration 10 -> 6 takes effect at the period boundary
        mode = 2'b00;
        cyc(2);
        set_cfg(10, 2, 3, 5, 20, 0);
        push_period(10, 2, 3, 5, 20);
        push_period(6, 2, 3, 5, 20);
        push_period(6, 2, 3, 5, 20);
        mode = 2'b01;
        cyc(5);
        set_cfg(6, 2, 3, 5, 20, 0);
        cyc(16);
        mode = 2'b00;
        cyc(3);
        chk("reload_drained", exp_q.size(), 0);

        // Fault at count 3 of a pulse, then interlock release
        set_cfg(10, 2, 5, 0, 0, 0);
        exp_q.push_back(2'b00); exp_q.push_back(2'b00); exp_q.push_back(2'b01);
        mode = 2'b01;
        cyc(4);
        chk("pre_fault_pulse", int'(pulse_out), 1);
        fault = 1'b1;
        cyc(1);
        chk("fault_pulse_low", int'(pulse_out), 0);
        chk("fault_active_low", int'(period_active), 0);
        chk("fault_laser_disable", int'(laser_disable), 1);
        chk("fault_latched", int'(fault_latched), 1);
        chk("fault_busy", int'(busy), 0);
        mode = 2'b00;
        cyc(2);
        fault_clear = 1'b1;
        cyc(1);
        fault_clear = 1'b0;
        chk("clear_with_fault", int'(fault_latched), 1);
        fault = 1'b0;
        cyc(2);
        chk("fault_held_mode_off", int'(fault_latched), 1);
        fault_clear = 1'b1;
        cyc(1);
        fault_clear = 1'b0;
        chk("fault_exit_latched", int'(fault_latched), 0);
        chk("fault_exit_disable", int'(laser_disable), 0);
        cyc(2);
        chk("fault_drained", exp_q.size(), 0);

        // Reset in mid-pulse leaves nothing behind
        exp_q.push_back(2'b00); exp_q.push_back(2'b00);
        exp_q.push_back(2'b01); exp_q.push_back(2'b01);
        mode = 2'b01;
        cyc(5);
        chk("pre_reset_pulse", int'(pulse_out), 1);
        rstn = 1'b0;
        cyc(1);
        chk("mid_reset_pulse", int'(pulse_out), 0);
        chk("mid_reset_active", int'(period_active), 0);
        chk("mid_reset_disable", int'(laser_disable), 1);
        mode = 2'b00;
        cyc(2);
        rstn = 1'b1;
        cyc(4);
        chk("post_reset_disable", int'(laser_disable), 0);
        chk("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/laser_pulse_sequencer.md
LASER_PULSE_SEQUENCER -- requirements
Module: laser_pulse_sequencer

Interface
REQ-001 The parameter NUM_CH SHALL default to 2 and set the number of pulse output channels (1..8).
REQ-002 The parameter CNT_W SHALL default to 24 and set the width of the period, delay and pulse-width counters.
REQ-003 The parameter BURST_W SHALL default to 16 and set the width of the burst counter.
REQ-004 The block SHALL have a single clock, clk (in, 1), and a synchronous active-low reset, rstn (in, 1).
REQ-005 The input cfg_update (1) SHALL be a single-cycle strobe that requests loading of the shadow configuration.
REQ-006 The input period (CNT_W) SHALL set the common period length, in clk cycles.
REQ-007 The inputs delay and pulse_width (NUM_CH*CNT_W each) SHALL carry the per-channel values, with channel i in bits [i*CNT_W +: CNT_W].
REQ-008 The input mode (2) SHALL select the operating mode: 00 off, 01 continuous, 10 triggered single period, 11 burst.
REQ-009 The input burst_count (BURST_W) SHALL set the number of periods run per trigger in burst mode.
REQ-010 The inputs sw_trigger (1, single-cycle strobe) and trigger_ext (1, asynchronous pin) SHALL be the two trigger sources.
REQ-011 The inputs fault (1, active-high over-current) and fault_clear (1, strobe) SHALL control the fault interlock.
REQ-012 The outputs pulse_out (NUM_CH), period_active (1), busy (1), fault_latched (1), laser_disable (1) and periods_done (BURST_W) SHALL all be registered.

Function
REQ-013 The state machine SHALL have exactly the states IDLE, ARMED, RUN and FAULT.
REQ-014 IDLE SHALL go to RUN when mode=01, and to ARMED when mode is 10 or 11.
REQ-015 ARMED SHALL go to RUN on a trigger event, defined as sw_trigger OR a rising edge of synchronised trigger_ext.
REQ-016 trigger_ext SHALL pass through a 2-FF synchroniser and a rising-edge detector, so that a pin edge reaches RUN 3 clk later.
REQ-017 In RUN, a period counter SHALL count 0..P-1, where P is the latched period, and P values below 2 SHALL be treated as 2.
REQ-018 Counter value 0 SHALL be the first cycle after entering RUN.
REQ-019 For each channel i, pulse_out[i] SHALL be high one clk after each counter value c that satisfies delay_i <= c < min(delay_i + width_i, P-1).
REQ-020 A width_i of 0, or a delay_i >= P-1, SHALL hold channel i low for the whole period.
REQ-021 period_active SHALL be high for all RUN cycles, with the same 1-clk registration as pulse_out.
REQ-022 At each period end (c=P-1):
  - mode 01 SHALL wrap the counter to 0;
  - mode 10 SHALL return to ARMED;
  - mode 11 SHALL increment periods_done and return to ARMED once periods_done reaches burst_count.
REQ-023 In mode 11, a trigger with burst_count=0 SHALL produce no RUN cycles and SHALL stay in ARMED.
REQ-024 periods_done SHALL clear on entry to RUN from ARMED and SHALL saturate at all-ones.
REQ-025 Trigger events received while in RUN SHALL be ignored and SHALL NOT be queued.
REQ-026 The shadow registers (period, delay, pulse_width, burst_count) SHALL load on cfg_update in IDLE or ARMED.
REQ-027 A cfg_update received in RUN SHALL be held pending and SHALL load at the next period end, before the next period starts.
REQ-028 mode=00 SHALL force IDLE on the next clk from ARMED or RUN, with outputs low the following clk, and SHALL NOT abort FAULT.
REQ-029 A change of mode made while in RUN SHALL take effect at the next period end, except for a change to 00.
REQ-030 fault high in any state SHALL enter FAULT on the next clk, and pulse_out and period_active SHALL be low in that same registered update.
REQ-031 In FAULT, fault_latched and laser_disable SHALL be 1 and all counters SHALL hold.
REQ-032 FAULT SHALL exit to IDLE only on fault_clear while fault is low, and when fault and fault_clear occur together, fault SHALL win.
REQ-033 busy SHALL be 1 in RUN and 0 in all other states.

Reset
REQ-034 With rstn low at a clk edge, the state SHALL be IDLE and all outputs SHALL be 0, except laser_disable, which SHALL be 1.
REQ-035 With rstn low at a clk edge, the shadow registers, pending flag and synchroniser SHALL be 0.
REQ-036 laser_disable SHALL deassert one clk after the first non-reset edge, provided fault is low.
REQ-037 A reset asserted in mid-period SHALL abort within the same edge and SHALL leave no residual pulse.

Structure
REQ-038 The mode encodings, state encodings and the minimum-period constant (2) SHALL reside in a shared package, laser_pkg.
REQ-039 The per-channel compare logic SHALL be a sub-module, pulse_channel, instantiated NUM_CH times by generate.

Verification
REQ-040 Scenario: mode=01, P=10, ch0 delay=2 width=3 -> pulse_out[0] is high for counts 2..4 of every period (registered), for 5 periods.
REQ-041 Scenario: mode=11, burst_count=3, sw_trigger -> exactly 3 periods run, then periods_done=3, then ARMED; a second sw_trigger during RUN is ignored.
REQ-042 Scenario: mode=10, trigger_ext rising edge -> RUN starts 3 clk later and exactly one period runs.
REQ-043 Scenario: fault asserted at count 3 of a pulse -> pulse_out=0 next clk and laser_disable=1; fault_clear applied with fault high -> stays in FAULT; fault_clear with fault low -> IDLE.
REQ-044 Scenario: cfg_update in RUN changing P from 10 to 6 -> the current period completes at 10 and the next period is 6.
REQ-045 Scenario: ch1 width=20 with P=10 -> output clamped to go low at c=9; and with P=1 -> the block behaves as P=2.
